// File: rtl/fuzz_pkg.sv
// rtl/fuzz_pkg.sv - shared types for the central fuzz controller and per-IP agents
package fuzz_pkg;

    localparam int RESULT_W = 33;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_LOG,
        ST_ADVANCE,
        ST_DONE
    } ctrl_state_t;

    typedef enum logic [1:0] {
        STATUS_OK    = 2'b00,
        STATUS_CRASH = 2'b01,
        STATUS_HANG  = 2'b10
    } status_t;

    // Log entry body; the controller prepends the agent id, whose width depends on NUM_IPS
    typedef struct packed {
        status_t               status;
        logic [RESULT_W-1:0]   result;
    } log_rec_t;

endpackage

// File: rtl/fuzz_log_fifo.sv
// rtl/fuzz_log_fifo.sv - show-ahead status log FIFO with count and same-cycle push/pop
module fuzz_log_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fuzz_central_controller.sv
// rtl/fuzz_central_controller.sv - round-robin session scheduler for per-IP fuzz agents
module fuzz_central_controller
    import fuzz_pkg::*;
#(
    parameter int NUM_IPS     = 4,
    parameter int MAX_ROUNDS  = 16,
    parameter int ACK_TIMEOUT = 200,
    parameter int LOG_DEPTH   = 16,
    parameter int CRASH_HALT  = 1,
    localparam int IDW = ($clog2(NUM_IPS) > 1) ? $clog2(NUM_IPS) : 1,
    localparam int CW  = $clog2(LOG_DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          stop,
    output logic [NUM_IPS-1:0]            ip_enable,
    input  logic [NUM_IPS-1:0]            ip_ack,
    input  logic [NUM_IPS-1:0]            ip_crash,
    input  logic [NUM_IPS*RESULT_W-1:0]   ip_output,
    output logic                          busy,
    output logic                          done,
    output logic [7:0]                    crash_count,
    input  logic                          log_rd_en,
    output logic [IDW+2+RESULT_W-1:0]     log_rd_data,
    output logic                          log_empty,
    output logic [CW-1:0]                 log_count,
    output logic                          log_overflow
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_ROUNDS + 1);

    ctrl_state_t         state;
    ctrl_state_t         state_next;
    logic [IDW-1:0]      cur_ip;
    logic [RW-1:0]       round;
    logic [TW-1:0]       timer;
    logic                stop_q;
    log_rec_t            rec;
    logic                push;
    logic                fifo_full;
    logic                cur_ack;
    logic                cur_crash;
    logic [RESULT_W-1:0] cur_output;
    logic                timeout;
    logic                last_ip;
    logic                halt;

    assign cur_ack    = ip_ack[cur_ip];
    assign cur_crash  = ip_crash[cur_ip];
    assign cur_output = ip_output[cur_ip*RESULT_W +: RESULT_W];
    assign timeout    = (timer == TW'(ACK_TIMEOUT - 1));
    assign last_ip    = (cur_ip == IDW'(NUM_IPS - 1));
    assign halt       = stop_q
                     || ((CRASH_HALT != 0) && (rec.status != STATUS_OK))
                     || (last_ip && (round == RW'(MAX_ROUNDS - 1)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ip_enable  = '0;
        busy       = 1'b0;
        done       = 1'b0;
        push       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                ip_enable[cur_ip] = 1'b1;
                busy              = 1'b1;
                state_next        = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                ip_enable[cur_ip] = 1'b1;
                busy              = 1'b1;
                if (cur_ack || timeout) state_next = ST_LOG;
            end
            ST_LOG: begin
                busy       = 1'b1;
                push       = 1'b1;
                state_next = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                busy       = 1'b1;
                state_next = halt ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_next = ST_ISSUE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_ip       <= '0;
            round        <= '0;
            timer        <= '0;
            stop_q       <= 1'b0;
            crash_count  <= '0;
            rec          <= '0;
            log_overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        cur_ip      <= '0;
                        round       <= '0;
                        crash_count <= '0;
                        stop_q      <= 1'b0;
                    end
                end
                ST_ISSUE: timer <= '0;
                ST_WAIT_ACK: begin
                    timer <= timer + 1'b1;
                    // Ack is checked first so a same-cycle ack beats the timeout
                    if (cur_ack) begin
                        rec.status <= cur_crash ? STATUS_CRASH : STATUS_OK;
                        rec.result <= cur_output;
                    end else if (timeout) begin
                        rec.status <= STATUS_HANG;
                        rec.result <= '0;
                    end
                end
                ST_LOG: begin
                    if ((rec.status != STATUS_OK) && (crash_count != 8'hFF)) begin
                        crash_count <= crash_count + 8'd1;
                    end
                    if (fifo_full && !log_rd_en) begin
                        log_overflow <= 1'b1;
                    end
                end
                ST_ADVANCE: begin
                    if (last_ip) begin
                        cur_ip <= '0;
                        round  <= round + 1'b1;
                    end else begin
                        cur_ip <= cur_ip + 1'b1;
                    end
                end
                default: ;
            endcase
            if (stop && (state != ST_IDLE) && (state != ST_DONE)) begin
                stop_q <= 1'b1;
            end
        end
    end

    fuzz_log_fifo #(
        .WIDTH (IDW + 2 + RESULT_W),
        .DEPTH (LOG_DEPTH)
    ) u_log_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({cur_ip, rec}),
        .pop       (log_rd_en),
        .head      (log_rd_data),
        .empty     (log_empty),
        .full      (fifo_full),
        .count     (log_count)
    );

endmodule

// File: tb/tb_fuzz_central_controller.sv
// tb/tb_fuzz_central_controller.sv - self-checking bench for fuzz_central_controller
module tb_fuzz_central_controller;
    import fuzz_pkg::*;

    localparam int NUM_IPS     = 4;
    localparam int MAX_ROUNDS  = 2;
    localparam int ACK_TIMEOUT = 10;
    localparam int LOG_DEPTH   = 4;
    localparam int CRASH_HALT  = 1;
    localparam int IDW         = 2;
    localparam int EW          = IDW + 2 + RESULT_W;
    localparam int CW          = 3;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        start = 1'b0;
    logic                        stop = 1'b0;
    logic                        log_rd_en = 1'b0;
    logic [NUM_IPS-1:0]          ip_enable;
    logic [NUM_IPS-1:0]          ip_ack = '0;
    logic [NUM_IPS-1:0]          ip_crash = '0;
    logic [NUM_IPS*RESULT_W-1:0] ip_output;
    logic                        busy;
    logic                        done;
    logic [7:0]                  crash_count;
    logic [EW-1:0]               log_rd_data;
    logic                        log_empty;
    logic [CW-1:0]               log_count;
    logic                        log_overflow;

    int              ack_delay [NUM_IPS];
    logic [32:0]     out_cfg   [NUM_IPS];
    int              agent_cnt [NUM_IPS];
    int              en_cnt    [NUM_IPS];
    int              exp_en    [NUM_IPS];
    int              onehot_err;
    int              n_checks = 0;
    int              n_fail = 0;
    logic [EW-1:0]   exp_q [$];
    bit              exp_ovf = 1'b0;
    int              exp_cc;

    fuzz_central_controller #(
        .NUM_IPS     (NUM_IPS),
        .MAX_ROUNDS  (MAX_ROUNDS),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .LOG_DEPTH   (LOG_DEPTH),
        .CRASH_HALT  (CRASH_HALT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .ip_enable    (ip_enable),
        .ip_ack       (ip_ack),
        .ip_crash     (ip_crash),
        .ip_output    (ip_output),
        .busy         (busy),
        .done         (done),
        .crash_count  (crash_count),
        .log_rd_en    (log_rd_en),
        .log_rd_data  (log_rd_data),
        .log_empty    (log_empty),
        .log_count    (log_count),
        .log_overflow (log_overflow)
    );

    always #5 clk = ~clk;

    always_comb begin
        ip_output = '0;
        for (int i = 0; i < NUM_IPS; i++) ip_output[i*RESULT_W +: RESULT_W] = out_cfg[i];
    end

    // Agent: pulses ack on the ack_delay-th cycle of its enable (0 = never acks)
    always @(negedge clk) begin
        for (int i = 0; i < NUM_IPS; i++) begin
            ip_ack[i] = 1'b0;
            if (ip_enable[i]) begin
                agent_cnt[i]++;
                if (agent_cnt[i] == ack_delay[i]) ip_ack[i] = 1'b1;
            end else begin
                agent_cnt[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NUM_IPS; i++) if (ip_enable[i]) en_cnt[i]++;
        if ($countones(ip_enable) > 1) onehot_err++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk sessions in round-robin order and derive each record from the agent config
    task automatic model(input int stop_ip);
        bit          fin;
        bit          hang;
        logic [1:0]  st;
        logic [32:0] res;
        fin    = 1'b0;
        exp_cc = 0;
        for (int i = 0; i < NUM_IPS; i++) exp_en[i] = 0;
        for (int r = 0; r < MAX_ROUNDS && !fin; r++) begin
            for (int i = 0; i < NUM_IPS && !fin; i++) begin
                hang = (ack_delay[i] < 2) || (ack_delay[i] > ACK_TIMEOUT + 1);
                st   = hang ? 2'd2 : (ip_crash[i] ? 2'd1 : 2'd0);
                res  = hang ? 33'd0 : out_cfg[i];
                exp_en[i] += hang ? ACK_TIMEOUT + 1 : ack_delay[i];
                if (exp_q.size() < LOG_DEPTH) exp_q.push_back({2'(i), st, res});
                else exp_ovf = 1'b1;
                if (st != 2'd0 && exp_cc < 255) exp_cc++;
                if ((CRASH_HALT != 0 && st != 2'd0) || (i == stop_ip && r == 0)) fin = 1'b1;
            end
        end
    endtask

    task automatic run_campaign(input int stop_ip);
        int cyc;
        bit stopped;
        for (int i = 0; i < NUM_IPS; i++) en_cnt[i] = 0;
        onehot_err = 0;
        model(stop_ip);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        stopped = 1'b0;
        while (!done && cyc < 3000) begin
            if (stop_ip >= 0 && !stopped && ip_enable[stop_ip] && en_cnt[stop_ip] >= 1) begin
                stop = 1'b1;
                stopped = 1'b1;
            end else begin
                stop = 1'b0;
            end
            start = (cyc == 7);
            @(posedge clk); #1;
            cyc++;
        end
        stop  = 1'b0;
        start = 1'b0;
        chk("campaign_in_budget", cyc < 3000, 1);
        chk("done", done, 1);
        chk("busy_after_done", busy, 0);
        chk("crash_count", crash_count, exp_cc);
        chk("log_count", log_count, exp_q.size());
        chk("log_overflow", log_overflow, exp_ovf);
        for (int i = 0; i < NUM_IPS; i++) chk($sformatf("enable_cycles[%0d]", i), en_cnt[i], exp_en[i]);
        chk("enable_onehot", onehot_err, 0);
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            chk("log_nonempty", log_empty, 0);
            chk("log_rd_data", log_rd_data, exp_q.pop_front());
            log_rd_en = 1'b1;
            @(posedge clk); #1;
            log_rd_en = 1'b0;
        end
        chk("log_empty_after_drain", log_empty, 1);
        chk("log_count_after_drain", log_count, 0);
    endtask

    initial begin
        for (int i = 0; i < NUM_IPS; i++) begin
            ack_delay[i] = 5;
            out_cfg[i]   = 33'hAB + 33'(i);
            agent_cnt[i] = 0;
            en_cnt[i]    = 0;
        end
        onehot_err = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ip_enable", ip_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_crash_count", crash_count, 0);
        chk("rst_log_empty", log_empty, 1);
        chk("rst_log_count", log_count, 0);
        chk("rst_log_overflow", log_overflow, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two clean rounds overflow a 4-deep log with no reads
        run_campaign(-1);
        drain();
        log_rd_en = 1'b1;
        @(posedge clk); #1;
        log_rd_en = 1'b0;
        chk("pop_empty_log_empty", log_empty, 1);
        chk("pop_empty_log_count", log_count, 0);

        ip_crash = 4'b0100;
        run_campaign(-1);
        drain();

        ip_crash = '0;
        ack_delay[1] = 0;
        run_campaign(-1);
        drain();

        // Stop during agent 1's session; restart from DONE keeps the log
        ack_delay[1] = 9;
        run_campaign(1);
        for (int i = 0; i < NUM_IPS; i++) ack_delay[i] = 3;
        run_campaign(-1);
        drain();

        // Ack on the timeout cycle, ack on first wait cycle, ack too late
        ack_delay[0] = 11;
        ack_delay[1] = 2;
        ack_delay[2] = 12;
        ack_delay[3] = 5;
        run_campaign(-1);
        drain();

        repeat (6) begin
            for (int i = 0; i < NUM_IPS; i++) begin
                ack_delay[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 11));
                ip_crash[i]  = ($urandom_range(0, 7) == 0);
                out_cfg[i]   = {1'($urandom_range(0, 1)), 32'($urandom())};
            end
            run_campaign(($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 3)));
            drain();
        end

        // Leave one record in the log, then reset in the middle of a session
        for (int i = 0; i < NUM_IPS; i++) ack_delay[i] = 0;
        ack_delay[0] = 3;
        ip_crash = 4'b0001;
        run_campaign(-1);
        ip_crash = '0;
        ack_delay[0] = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_busy", busy, 1);
        chk("pre_reset_enable", ip_enable, 4'b0001);
        chk("pre_reset_log_count", log_count, exp_q.size());
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        exp_ovf = 1'b0;
        chk("mid_rst_ip_enable", ip_enable, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_log_empty", log_empty, 1);
        chk("mid_rst_log_count", log_count, 0);
        chk("mid_rst_crash_count", crash_count, 0);
        chk("mid_rst_log_overflow", log_overflow, exp_ovf);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
